note_track: RTL

- Chart sequencer and lane scroller; the producer end of the per-lane 2-bit note-window code consumed by the hit judges and combo counter.
- Fetches one 4-lane chart row per beat from a synchronous chart ROM and shifts rows down four lane tracks.
- Drives per-lane window codes (bit1 = note in bottom/perfect row, bit0 = note in next-to-bottom/good row).
- Provides a one-cycle step strobe for the score and combo counter enables, and the full track image for the VGA renderer.

---
 rtl/note_track_if.sv | 48 ++++
 rtl/note_track.sv | 134 +++++++++++++
 2 files changed

// File: rtl/note_track_if.sv
// Chart-sequencer bus: song control, chart ROM port, lane window codes and track image.
interface note_track_if #(
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned ADDR_W    = 6
);
  logic                   start;
  logic                   pause;
  logic [ADDR_W-1:0]      chart_addr;
  logic [3:0]             chart_data;
  logic [1:0]             note1;
  logic [1:0]             note2;
  logic [1:0]             note3;
  logic [1:0]             note4;
  logic [4*TRACK_LEN-1:0] track;
  logic                   step;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output pause,
    output chart_data,
    input  chart_addr,
    input  note1,
    input  note2,
    input  note3,
    input  note4,
    input  track,
    input  step,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  pause,
    input  chart_data,
    output chart_addr,
    output note1,
    output note2,
    output note3,
    output note4,
    output track,
    output step,
    output busy,
    output done
  );
endinterface

// File: rtl/note_track.sv
// Chart sequencer and 4-lane scroller feeding the hit judges, combo counter and renderer.
// Define NOTE_TRACK_LOOP_EN to replay the chart forever instead of draining to DONE.
module note_track #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned CHART_LEN = 64
) (
  input logic        clk,
  input logic        resetn,
  note_track_if.slave bus
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntMax = (CHART_LEN > TRACK_LEN) ? CHART_LEN : TRACK_LEN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]  ChartLast = CntW'(CHART_LEN - 1);
  localparam logic [CntW-1:0]  TrackLast = CntW'(TRACK_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDrain,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [4*TRACK_LEN-1:0] track_q, track_d;
  logic                   step_q, step_d;

  logic                   running;
  logic                   step_now;
  logic [3:0]             row_in;

  assign running  = (state_q == StPlay) || (state_q == StDrain);
  assign step_now = running && !bus.pause && (tick_q == TickLast);
  // Chart data is only consumed while playing; drain steps push empty rows.
  assign row_in   = (state_q == StPlay) ? bus.chart_data : 4'b0000;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    track_d = track_q;
    step_d  = 1'b0;

    if (!bus.pause) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_d = StPlay;
            tick_d  = '0;
            cnt_d   = '0;
            addr_d  = '0;
            track_d = '0;
          end
        end

        StPlay, StDrain: begin
          if (step_now) begin
            tick_d = '0;
            step_d = 1'b1;
            for (int l = 0; l < 4; l++) begin
              track_d[l*TRACK_LEN +: TRACK_LEN] =
                {track_q[l*TRACK_LEN +: (TRACK_LEN-1)], row_in[l]};
            end

            if (state_q == StPlay) begin
              addr_d = addr_q + ADDR_W'(1);
              cnt_d  = cnt_q + CntW'(1);
              if (cnt_q == ChartLast) begin
                cnt_d = '0;
`ifdef NOTE_TRACK_LOOP_EN
                addr_d = '0;
`else
                state_d = StDrain;
`endif
              end
            end else begin
              cnt_d = cnt_q + CntW'(1);
              if (cnt_q == TrackLast) begin
                cnt_d   = '0;
                state_d = StDone;
              end
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      tick_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      track_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      track_q <= track_d;
      step_q  <= step_d;
    end
  end

  // Window code: bit1 = bottom (perfect) row, bit0 = next-to-bottom (good) row.
  assign bus.note1 = {track_q[0*TRACK_LEN + TRACK_LEN-1], track_q[0*TRACK_LEN + TRACK_LEN-2]};
  assign bus.note2 = {track_q[1*TRACK_LEN + TRACK_LEN-1], track_q[1*TRACK_LEN + TRACK_LEN-2]};
  assign bus.note3 = {track_q[2*TRACK_LEN + TRACK_LEN-1], track_q[2*TRACK_LEN + TRACK_LEN-2]};
  assign bus.note4 = {track_q[3*TRACK_LEN + TRACK_LEN-1], track_q[3*TRACK_LEN + TRACK_LEN-2]};

  assign bus.chart_addr = addr_q;
  assign bus.track      = track_q;
  assign bus.step       = step_q;
  assign bus.busy       = running;
  assign bus.done       = (state_q == StDone);

endmodule
